wb_sram_reader: RTL and testbench
=================================

# wb_sram_reader

Wishbone classic slave that gives the management SoC read-only access to the L1 cache SRAM macros through their second (read-only) port. The Marmot core writes and reads these macros through port 0; this block is the other reader, driving each macro's `csb1`/`addr1` and returning `dout1` over Wishbone. It replaces the logic-analyzer-driven port-1 hookup in the Caravel user wrapper and is instantiated alongside `MarmotCaravelChip`.

## Interface
**Parameters**
- `BASE_ADR`, `32'h3000_0000`: decoded base address; match when `wbs_adr_i[31:16] == BASE_ADR[31:16]`.
- `RD_WAIT`, `1`: cycles between port-1 select and data capture. Legal range is 1–7.

**Ports**
- `wb_clk_i` in 1: the single clock for the block and for SRAM port 1.
- `wb_rst_i` in 1: reset, synchronous, active-high.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` in 1: Wishbone strobe, cycle, write enable.
- `wbs_sel_i` in 4: byte selects. Ignored.
- `wbs_dat_i` in 32: write data. Ignored.
- `wbs_adr_i` in 32: byte address.
- `wbs_ack_o` out 1: acknowledge. Registered.
- `wbs_dat_o` out 32: read data. Registered.
- `tag_array_ext_ram_csb1` out 2: port-1 chip selects, active-low, one per tag macro.
- `tag_array_ext_ram_addr1` out 8: port-1 row address for the tag macros.
- `tag_array_ext_ram_dout1_0`, `_dout1_1` in 32 each: port-1 read data from the tag macros.
- `data_arrays_0_0_ext_ram_csb1` out 8: port-1 chip selects, active-low. Bits [7:4] are tied high.
- `data_arrays_0_0_ext_ram_addr1` out 9: port-1 row address for the data macros.
- `data_arrays_0_0_ext_ram_dout1_0` … `_dout1_3` in 64 each: port-1 read data from the data macros.

## Operation
**Address map** (by offset bits `[15:14]`)
- `0` tag array:
  - `addr1 = adr[9:2]`
  - macro select = `adr[10]`
  - returned word = `doutN[31:0]`
- `1` data_arrays_0_0:
  - `addr1 = adr[11:3]`
  - macro select = `adr[13:12]`
  - `adr[2]` selects `[63:32]` when 1, `[31:0]` when 0
- `2` unmapped: reads return `32'h0`.
- `3` status register when `SRAM_READER_STATUS_EN` is defined, otherwise returns `32'h0`.

**Request acceptance:** `stb & cyc` in IDLE with an address match.

**FSM states:** IDLE, SEL, WAIT, ACK.
- IDLE → SEL: accepted read to region 0 or 1.
  - The selected `csb1` bit goes low for exactly one cycle (SEL).
  - `addr1` is registered at the same time.
- IDLE → ACK: accepted write, or read to region 2 or 3.
  - Writes have no side effects.
- SEL → WAIT: the `csb1` bits return high, and `addr1` is held.
- WAIT: counts `RD_WAIT` cycles, then captures the selected half-word into `wbs_dat_o` and goes to ACK.
- ACK: `wbs_ack_o = 1` for exactly one cycle, then IDLE.
  - `wbs_dat_o` holds its value until the next capture.
- Abort: `cyc` low in SEL or WAIT sends the FSM to IDLE with no ack and no data update.

**Fixed behaviour**
- At most one port-1 access is in flight.
- All unselected `csb1` bits stay high at all times.
- A port-1 read of a row that port 0 writes in the same cycle returns undefined data. This is not flagged; software quiesces the cache first.

## Timing
**Reset values:** `wbs_ack_o = 0`, `wbs_dat_o = 0`, all `csb1 = 1`, all `addr1 = 0`, FSM = IDLE, counter = 0.

**Latency** (request sampled at edge E0)
- Read: `csb1` low during cycle E0–E1.
  - Data is captured at edge E1+`RD_WAIT`.
  - Ack is high in the following cycle.
  - Total: `RD_WAIT + 2` cycles from accept to ack.
- Write or non-SRAM read: ack is high in cycle E0–E1, i.e. 1 cycle.

**Back-to-back:** a new request is accepted no earlier than the cycle after ACK. A master holding `stb` through the ack is not double-accepted.

**Reset mid-transaction:** `wb_rst_i` forces all reset values at the next edge, with no ack.

## Configuration
- **`SRAM_READER_STATUS_EN` defined:**
  - Region 3 read returns `{16'h0, rd_count[15:0]}`.
  - `rd_count` increments on each completed SRAM read (region 0 or 1 ack) and wraps `16'hFFFF` → `0`.
  - A write to region 3 clears the counter.
- **Undefined:** there is no counter logic, and region 3 reads return `32'h0`.

## Test plan
- Reset, then idle 5 cycles → `ack = 0`, `dat_o = 0`, `tag csb1 = 2'b11`, `data csb1 = 8'hFF` throughout.
- Model macro 1 of the tag array returning `32'hA5A5_0012` for row 8; read `0x3000_0420` → `tag csb1 = 2'b01` for 1 cycle with `addr1 = 8'h08`; ack at accept+3 with `dat_o = 32'hA5A5_0012`.
- Model data macro 2 row `0x1F3` = `64'h1122_3344_5566_7788`; read `0x3000_6F9C` → `csb1[2]` low, `addr1 = 9'h1F3`, `dat_o = 32'h1122_3344`. The same read with `adr[2] = 0` returns `32'h5566_7788`.
- Write to `0x3000_0000` → ack after 1 cycle, no `csb1` activity, `wbs_dat_o` unchanged. A read of `0x3000_8000` → ack after 1 cycle, `dat_o = 0`.
- Drop `cyc` during WAIT → no ack; the next read completes normally. Assert `wb_rst_i` during SEL → all outputs at reset values the next cycle.
- With `SRAM_READER_STATUS_EN` defined: 3 SRAM reads then read `0x3000_C000` → `32'h0000_0003`; write there, then read again → `32'h0`.

Source files
------------

// File: rtl/wb_sram_reader_if.sv
// Wishbone classic slave bus bundle for wb_sram_reader; signal names match
// the original Caravel wrapper ports.
interface wb_sram_reader_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_sram_reader.sv
// Read-only Wishbone window onto port 1 of the L1 tag/data SRAM macros.
// Optional read counter at region 3 is enabled by defining SRAM_READER_STATUS_EN.
module wb_sram_reader #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int unsigned RD_WAIT  = 1
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  wb_sram_reader_if.slave        wbs,
  output logic [1:0]             tag_array_ext_ram_csb1,
  output logic [7:0]             tag_array_ext_ram_addr1,
  input  logic [31:0]            tag_array_ext_ram_dout1_0,
  input  logic [31:0]            tag_array_ext_ram_dout1_1,
  output logic [7:0]             data_arrays_0_0_ext_ram_csb1,
  output logic [8:0]             data_arrays_0_0_ext_ram_addr1,
  input  logic [63:0]            data_arrays_0_0_ext_ram_dout1_0,
  input  logic [63:0]            data_arrays_0_0_ext_ram_dout1_1,
  input  logic [63:0]            data_arrays_0_0_ext_ram_dout1_2,
  input  logic [63:0]            data_arrays_0_0_ext_ram_dout1_3
);

  typedef enum logic [1:0] {S_IDLE, S_SEL, S_WAIT, S_ACK} state_e;

  localparam logic [2:0] LAST = 3'(RD_WAIT - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        region_q, region_d;
  logic [1:0]  msel_q, msel_d;
  logic        hi_q, hi_d;
  logic [7:0]  tag_addr_q, tag_addr_d;
  logic [8:0]  data_addr_q, data_addr_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] rd_word;
  logic [63:0] data_word;
  logic [31:0] status_word;
  logic        match, accept, sram_rd, capture;
  logic        unused_ok;

  assign match   = (wbs.wbs_adr_i[31:16] == BASE_ADR[31:16]);
  assign accept  = (state_q == S_IDLE) && wbs.wbs_stb_i && wbs.wbs_cyc_i && match;
  assign sram_rd = !wbs.wbs_we_i && !wbs.wbs_adr_i[15];
  assign capture = (state_q == S_WAIT) && wbs.wbs_cyc_i && (cnt_q == LAST);
  assign unused_ok = ^{wbs.wbs_sel_i, wbs.wbs_dat_i, wbs.wbs_adr_i[1:0]};

`ifdef SRAM_READER_STATUS_EN
  logic [15:0] rd_count_q;
  logic        sram_q;

  // sram_q remembers whether the transaction now acking was a port-1 read
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rd_count_q <= '0;
      sram_q     <= 1'b0;
    end else begin
      if (accept) sram_q <= sram_rd;
      if (accept && wbs.wbs_we_i && (wbs.wbs_adr_i[15:14] == 2'b11))
        rd_count_q <= '0;
      else if ((state_q == S_ACK) && sram_q)
        rd_count_q <= rd_count_q + 16'd1;
    end
  end
  assign status_word = {16'h0, rd_count_q};
`else
  assign status_word = '0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = sram_rd ? S_SEL : S_ACK;
      S_SEL:  state_d = wbs.wbs_cyc_i ? S_WAIT : S_IDLE;
      S_WAIT: begin
        if (!wbs.wbs_cyc_i) state_d = S_IDLE;
        else if (capture)   state_d = S_ACK;
      end
      S_ACK:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    data_word = data_arrays_0_0_ext_ram_dout1_0;
    unique case (msel_q)
      2'd0: data_word = data_arrays_0_0_ext_ram_dout1_0;
      2'd1: data_word = data_arrays_0_0_ext_ram_dout1_1;
      2'd2: data_word = data_arrays_0_0_ext_ram_dout1_2;
      2'd3: data_word = data_arrays_0_0_ext_ram_dout1_3;
      default: data_word = data_arrays_0_0_ext_ram_dout1_0;
    endcase
    if (!region_q) rd_word = msel_q[0] ? tag_array_ext_ram_dout1_1 : tag_array_ext_ram_dout1_0;
    else           rd_word = hi_q ? data_word[63:32] : data_word[31:0];
  end

  always_comb begin
    cnt_d       = (state_q == S_WAIT) ? cnt_q + 3'd1 : '0;
    region_d    = region_q;
    msel_d      = msel_q;
    hi_d        = hi_q;
    tag_addr_d  = tag_addr_q;
    data_addr_d = data_addr_q;
    dat_d       = dat_q;
    if (accept) begin
      if (sram_rd) begin
        region_d = wbs.wbs_adr_i[14];
        if (!wbs.wbs_adr_i[14]) begin
          tag_addr_d = wbs.wbs_adr_i[9:2];
          msel_d     = {1'b0, wbs.wbs_adr_i[10]};
        end else begin
          data_addr_d = wbs.wbs_adr_i[11:3];
          msel_d      = wbs.wbs_adr_i[13:12];
          hi_d        = wbs.wbs_adr_i[2];
        end
      end else if (!wbs.wbs_we_i) begin
        dat_d = wbs.wbs_adr_i[14] ? status_word : '0;
      end
    end
    if (capture) dat_d = rd_word;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_q       <= '0;
      region_q    <= 1'b0;
      msel_q      <= '0;
      hi_q        <= 1'b0;
      tag_addr_q  <= '0;
      data_addr_q <= '0;
      dat_q       <= '0;
    end else begin
      cnt_q       <= cnt_d;
      region_q    <= region_d;
      msel_q      <= msel_d;
      hi_q        <= hi_d;
      tag_addr_q  <= tag_addr_d;
      data_addr_q <= data_addr_d;
      dat_q       <= dat_d;
    end
  end

  // Chip selects decode from the registered state, so they are glitch-free per cycle
  always_comb begin
    tag_array_ext_ram_csb1       = '1;
    data_arrays_0_0_ext_ram_csb1 = '1;
    if (state_q == S_SEL) begin
      if (!region_q) tag_array_ext_ram_csb1[msel_q[0]] = 1'b0;
      else           data_arrays_0_0_ext_ram_csb1[{1'b0, msel_q}] = 1'b0;
    end
  end

  assign tag_array_ext_ram_addr1       = tag_addr_q;
  assign data_arrays_0_0_ext_ram_addr1 = data_addr_q;
  assign wbs.wbs_ack_o                 = (state_q == S_ACK);
  assign wbs.wbs_dat_o                 = dat_q;

endmodule

// File: tb/tb_wb_sram_reader.sv
// Self-checking bench for wb_sram_reader with behavioural port-1 SRAM models.
module tb_wb_sram_reader;
  localparam int unsigned RD_WAIT = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_sram_reader_if bus();

  logic [1:0]  tag_csb;
  logic [7:0]  tag_addr;
  logic [31:0] tag_dout0 = '0, tag_dout1 = '0;
  logic [7:0]  data_csb;
  logic [8:0]  data_addr;
  logic [63:0] data_dout0 = '0, data_dout1 = '0, data_dout2 = '0, data_dout3 = '0;

  wb_sram_reader #(.BASE_ADR(32'h3000_0000), .RD_WAIT(RD_WAIT)) dut (
    .wb_clk_i                        (clk),
    .wb_rst_i                        (rst),
    .wbs                             (bus),
    .tag_array_ext_ram_csb1          (tag_csb),
    .tag_array_ext_ram_addr1         (tag_addr),
    .tag_array_ext_ram_dout1_0       (tag_dout0),
    .tag_array_ext_ram_dout1_1       (tag_dout1),
    .data_arrays_0_0_ext_ram_csb1    (data_csb),
    .data_arrays_0_0_ext_ram_addr1   (data_addr),
    .data_arrays_0_0_ext_ram_dout1_0 (data_dout0),
    .data_arrays_0_0_ext_ram_dout1_1 (data_dout1),
    .data_arrays_0_0_ext_ram_dout1_2 (data_dout2),
    .data_arrays_0_0_ext_ram_dout1_3 (data_dout3)
  );

  int total = 0;
  int bad = 0;
  int sw_count = 0;
  logic [31:0] last_exp = '0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] tag_val(input int unsigned m, input logic [7:0] r);
    if (m == 1 && r == 8'h08) return 32'hA5A5_0012;
    return {16'hC0C0 ^ 16'(m), 8'h00, r};
  endfunction

  function automatic logic [63:0] data_val(input int unsigned m, input logic [8:0] r);
    if (m == 2 && r == 9'h1F3) return 64'h1122_3344_5566_7788;
    return {16'hDA00 | 16'(m), 7'h0, r, 16'h5A00 | 16'(m), 7'h0, r};
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [63:0] w;
    case (a[15:14])
      2'd0: return tag_val(32'(a[10]), a[9:2]);
      2'd1: begin
        w = data_val(32'(a[13:12]), a[11:3]);
        return a[2] ? w[63:32] : w[31:0];
      end
`ifdef SRAM_READER_STATUS_EN
      2'd3: return {16'h0, 16'(sw_count)};
`endif
      default: return '0;
    endcase
  endfunction

  // Synchronous-read macro models: data appears after the edge that samples csb low
  always @(posedge clk) begin
    if (!tag_csb[0]) tag_dout0 <= tag_val(0, tag_addr);
    if (!tag_csb[1]) tag_dout1 <= tag_val(1, tag_addr);
    if (!data_csb[0]) data_dout0 <= data_val(0, data_addr);
    if (!data_csb[1]) data_dout1 <= data_val(1, data_addr);
    if (!data_csb[2]) data_dout2 <= data_val(2, data_addr);
    if (!data_csb[3]) data_dout3 <= data_val(3, data_addr);
  end

  int tag_low[2];
  int data_low[8];
  logic [7:0] tag_a_seen;
  logic [8:0] data_a_seen;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++)
      if (tag_csb[i] !== 1'b1) begin tag_low[i]++; tag_a_seen = tag_addr; end
    for (int i = 0; i < 8; i++)
      if (data_csb[i] !== 1'b1) begin data_low[i]++; data_a_seen = data_addr; end
  end

  task automatic mon_clear();
    for (int i = 0; i < 2; i++) tag_low[i] = 0;
    for (int i = 0; i < 8; i++) data_low[i] = 0;
    tag_a_seen = 'x;
    data_a_seen = 'x;
  endtask

  task automatic bus_idle();
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = '0;   bus.wbs_dat_i = '0;   bus.wbs_adr_i = '0;
  endtask

  // One Wishbone transfer; lat counts edges from the accept edge to the edge after which ack is seen
  task automatic wb_xfer(input logic [31:0] adr, input logic we, output int lat,
                         output logic [31:0] dat, output bit to);
    @(negedge clk);
    bus.wbs_adr_i = adr; bus.wbs_we_i = we; bus.wbs_sel_i = '1;
    bus.wbs_dat_i = 32'hDEAD_BEEF; bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (bus.wbs_ack_o !== 1'b1 && lat < 20);
    to  = (bus.wbs_ack_o !== 1'b1);
    dat = bus.wbs_dat_o;
    bus_idle();
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_idle();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (bus.wbs_ack_o !== 1'b0 || bus.wbs_dat_o !== 32'h0 || tag_csb !== 2'b11 ||
          data_csb !== 8'hFF || tag_addr !== 8'h0 || data_addr !== 9'h0) begin
        bad++;
        $display("FAIL reset_idle cyc%0d: ack=%b dat=%h tcsb=%b dcsb=%h ta=%h da=%h (want 0 0 11 ff 0 0)",
                 i, bus.wbs_ack_o, bus.wbs_dat_o, tag_csb, data_csb, tag_addr, data_addr);
      end
    end
  endtask

  task automatic test_sram_reads();
    logic [31:0] tbl[5];
    logic [31:0] a, d, e;
    int lat;
    bit to;
    tbl = '{32'h3000_0420, 32'h3000_6F9C, 32'h3000_6F98, 32'h3000_0004, 32'h3000_4008};
    foreach (tbl[k]) begin
      a = tbl[k];
      mon_clear();
      exp_q.push_back(model_read(a));
      wb_xfer(a, 1'b0, lat, d, to);
      total++;
      if (to || lat != int'(RD_WAIT) + 2) begin
        bad++; $display("FAIL rd_latency %h: got=%0d timeout=%b want=%0d", a, lat, to, RD_WAIT + 2);
      end
      e = exp_q.pop_front();
      total++;
      if (d !== e) begin bad++; $display("FAIL rd_data %h: got=%h want=%h", a, d, e); end
      if (!to) begin sw_count++; last_exp = e; end
      total++;
      if (!a[14]) begin
        if (tag_low[a[10]] != 1 || tag_low[!a[10]] != 0 || data_low.sum() != 0 || tag_a_seen !== a[9:2]) begin
          bad++; $display("FAIL tag_port1 %h: lows=%0d/%0d dlows=%0d addr=%h want one low on %0d addr=%h",
                          a, tag_low[0], tag_low[1], data_low.sum(), tag_a_seen, a[10], a[9:2]);
        end
      end else begin
        if (data_low[a[13:12]] != 1 || data_low.sum() != 1 || tag_low.sum() != 0 || data_a_seen !== a[11:3]) begin
          bad++; $display("FAIL data_port1 %h: low_sel=%0d dlows=%0d tlows=%0d addr=%h want one low on %0d addr=%h",
                          a, data_low[a[13:12]], data_low.sum(), tag_low.sum(), data_a_seen, a[13:12], a[11:3]);
        end
      end
    end
  endtask

  task automatic test_nonsram();
    logic [31:0] d, e;
    int lat;
    bit to, seen;
    mon_clear();
    wb_xfer(32'h3000_0000, 1'b1, lat, d, to);
    total++;
    if (to || lat != 1 || d !== last_exp || tag_low.sum() + data_low.sum() != 0) begin
      bad++; $display("FAIL write_r0: lat=%0d to=%b dat=%h csb_lows=%0d want lat=1 dat=%h lows=0",
                      lat, to, d, tag_low.sum() + data_low.sum(), last_exp);
    end
    foreach (exp_q[i]) exp_q.delete(i);
    for (int k = 0; k < 2; k++) begin
      logic [31:0] a;
      a = (k == 0) ? 32'h3000_8000 : 32'h3000_C000;
      exp_q.push_back(model_read(a));
      wb_xfer(a, 1'b0, lat, d, to);
      e = exp_q.pop_front();
      total++;
      if (to || lat != 1 || d !== e) begin
        bad++; $display("FAIL reg_read %h: lat=%0d to=%b dat=%h want lat=1 dat=%h", a, lat, to, d, e);
      end
      if (!to) last_exp = e;
    end
    // An address outside the decoded window must be ignored entirely
    @(negedge clk);
    bus.wbs_adr_i = 32'h3001_0420; bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1;
    seen = 1'b0;
    mon_clear();
    repeat (5) begin @(posedge clk); #1; if (bus.wbs_ack_o !== 1'b0) seen = 1'b1; end
    bus_idle();
    total++;
    if (seen || tag_low.sum() != 0) begin
      bad++; $display("FAIL no_match: ack_seen=%b tag_lows=%0d want 0 0", seen, tag_low.sum());
    end
  endtask

  task automatic test_abort();
    logic [31:0] d, e;
    int lat;
    bit to, seen;
    @(negedge clk);
    bus.wbs_adr_i = 32'h3000_0420; bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus_idle();
    seen = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (bus.wbs_ack_o !== 1'b0) seen = 1'b1; end
    total++;
    if (seen || bus.wbs_dat_o !== last_exp) begin
      bad++; $display("FAIL abort: ack_seen=%b dat=%h want 0 %h", seen, bus.wbs_dat_o, last_exp);
    end
    exp_q.push_back(model_read(32'h3000_6F98));
    wb_xfer(32'h3000_6F98, 1'b0, lat, d, to);
    e = exp_q.pop_front();
    total++;
    if (to || lat != int'(RD_WAIT) + 2 || d !== e) begin
      bad++; $display("FAIL after_abort: lat=%0d to=%b dat=%h want lat=%0d dat=%h", lat, to, d, RD_WAIT + 2, e);
    end
    if (!to) begin sw_count++; last_exp = e; end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.wbs_adr_i = 32'h3000_6F9C; bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1;
    @(posedge clk); #1;
    total++;
    if (data_csb !== 8'hFB) begin bad++; $display("FAIL sel_csb: got=%h want=fb", data_csb); end
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.wbs_ack_o !== 1'b0 || bus.wbs_dat_o !== 32'h0 || tag_csb !== 2'b11 ||
        data_csb !== 8'hFF || tag_addr !== 8'h0 || data_addr !== 9'h0) begin
      bad++;
      $display("FAIL reset_mid: ack=%b dat=%h tcsb=%b dcsb=%h ta=%h da=%h (want 0 0 11 ff 0 0)",
               bus.wbs_ack_o, bus.wbs_dat_o, tag_csb, data_csb, tag_addr, data_addr);
    end
    bus_idle();
    @(negedge clk) rst = 1'b0;
    last_exp = '0;
    sw_count = 0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] e1, e2;
    int lat;
    bit got1;
    @(negedge clk);
    bus.wbs_adr_i = 32'h3000_0000; bus.wbs_we_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.wbs_ack_o !== 1'b1) begin bad++; $display("FAIL hold_write_ack: got=%b want=1", bus.wbs_ack_o); end
    @(posedge clk); #1;
    total++;
    if (bus.wbs_ack_o !== 1'b0) begin bad++; $display("FAIL hold_no_reaccept: ack=%b want=0", bus.wbs_ack_o); end
    bus_idle();
    @(posedge clk);
    // Two reads with stb held continuously; the second may only be accepted after ACK
    exp_q.push_back(model_read(32'h3000_0420));
    exp_q.push_back(model_read(32'h3000_6F9C));
    @(negedge clk);
    bus.wbs_adr_i = 32'h3000_0420; bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1;
    lat = 0;
    got1 = 1'b0;
    do begin @(posedge clk); #1; lat++; end while (bus.wbs_ack_o !== 1'b1 && lat < 20);
    e1 = exp_q.pop_front();
    total++;
    if (bus.wbs_ack_o !== 1'b1 || lat != int'(RD_WAIT) + 2 || bus.wbs_dat_o !== e1) begin
      bad++; $display("FAIL b2b_first: lat=%0d dat=%h want lat=%0d dat=%h", lat, bus.wbs_dat_o, RD_WAIT + 2, e1);
    end else got1 = 1'b1;
    bus.wbs_adr_i = 32'h3000_6F9C;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (bus.wbs_ack_o !== 1'b1 && lat < 20);
    e2 = exp_q.pop_front();
    total++;
    if (bus.wbs_ack_o !== 1'b1 || lat != int'(RD_WAIT) + 3 || bus.wbs_dat_o !== e2) begin
      bad++; $display("FAIL b2b_second: lat=%0d dat=%h want lat=%0d dat=%h", lat, bus.wbs_dat_o, RD_WAIT + 3, e2);
    end else begin
      last_exp = e2;
      sw_count++;
    end
    if (got1) sw_count++;
    bus_idle();
    @(posedge clk);
  endtask

`ifdef SRAM_READER_STATUS_EN
  task automatic test_status();
    logic [31:0] d, e;
    int lat;
    bit to;
    wb_xfer(32'h3000_C000, 1'b1, lat, d, to);
    sw_count = 0;
    for (int k = 0; k < 3; k++) begin
      wb_xfer(32'h3000_0420, 1'b0, lat, d, to);
      if (!to) sw_count++;
    end
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(model_read(32'h3000_C000));
      wb_xfer(32'h3000_C000, 1'b0, lat, d, to);
      e = exp_q.pop_front();
      total++;
      if (to || d !== e || d !== ((k == 0) ? 32'h3 : 32'h0)) begin
        bad++; $display("FAIL status_%0d: dat=%h to=%b want=%h", k, d, to, e);
      end
      if (k == 0) begin
        wb_xfer(32'h3000_C000, 1'b1, lat, d, to);
        sw_count = 0;
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sram_reads();
    test_nonsram();
    test_abort();
    test_reset_mid();
    test_back_to_back();
`ifdef SRAM_READER_STATUS_EN
    test_status();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
